regfile_access_arbiter: RTL
===========================

// Module: regfile_access_arbiter
// PURPOSE
//  Shares one single-port Register_File between two requesters (A, B) with round-robin arbitration.
//  Sequences each granted command into a one-cycle RF_WrEn/RF_RdEn strobe and returns read data.
//  Sits between the requesters and the register file. Guarantees RF_WrEn and RF_RdEn are never both high.
// PARAMETERS
//  MEM_WIDTH   16                  data width, matches Register_File
//  MEM_DEPTH   8                   register count, matches Register_File
//  ADDR_WIDTH  $clog2(MEM_DEPTH)   derived, do not override
// PORTS
//  CLK          in   1           clock, all logic on rising edge
//  RST          in   1           synchronous, active-high reset
//  Req_A/Req_B  in   1           command request per requester
//  Wr_A/Wr_B    in   1           1 = write, 0 = read
//  Addr_A/B     in   ADDR_WIDTH  target register
//  WrData_A/B   in   MEM_WIDTH   write data
//  Gnt_A/Gnt_B  out  1           1-cycle pulse: command accepted
//  RdValid_A/B  out  1           1-cycle pulse: RdData holds the result of that requester's read
//  RdData       out  MEM_WIDTH   read-return bus, shared by A and B
//  RF_WrEn      out  1           to Register_File WrEn
//  RF_RdEn      out  1           to Register_File RdEn
//  RF_Address   out  ADDR_WIDTH  to Register_File Address
//  RF_WrData    out  MEM_WIDTH   to Register_File WrData
//  RF_RdData    in   MEM_WIDTH   from Register_File RdData; registered, valid 1 cycle after RdEn edge
// BEHAVIOUR
//  Reset (RST high at an edge):
//   - state -> IDLE; last_gnt -> B, so A wins the first tie.
//   - All outputs -> 0, including RdData and RF_*. Any in-flight command is dropped; no RdValid issued.
//   - Register file contents are not touched.
//  FSM, 3 states, registered:
//   - IDLE: Req_A/Req_B sampled only here.
//     - If any Req: latch winner's Wr/Addr/WrData into cmd regs; set Gnt_x for the next cycle; -> ACCESS.
//     - Else stay.
//   - ACCESS: drive RF_Address/RF_WrData from cmd regs.
//     - Write: RF_WrEn = 1; -> IDLE.
//     - Read: RF_RdEn = 1; -> CAPTURE.
//   - CAPTURE: RdData <= RF_RdData; RdValid_x pulses next cycle; -> IDLE.
//  Arbitration:
//   - Single Req: that requester wins.
//   - Both Req: the requester not in last_gnt wins; last_gnt updates on every grant.
//  Handshake:
//   - Requester holds Req plus command stable until it sees Gnt.
//   - In the cycle after Gnt it either drops Req or presents its next command.
//   - Req high during ACCESS/CAPTURE is ignored, not lost: it is re-evaluated in IDLE.
//  Latency (sample edge = cycle 0):
//   - Gnt visible cycle 1.
//   - Write: RF_WrEn in cycle 1, committed at the end of cycle 1.
//   - Read: RF_RdEn in cycle 1, RF_RdData valid cycle 2, RdData/RdValid visible cycle 3.
//   - Throughput: write every 2 cycles, read every 3.
//  Outputs decode only from the state and cmd registers; no combinational path from Req/Addr/WrData inputs.
//  RdData holds its last value until the next CAPTURE. A write never alters RdData.
//  Reset in ACCESS with a write: RF_WrEn is 0 from that edge on. Whether the write completed depends only on the prior edge.
// STRUCTURE
//  Shared package regfile_ctrl_pkg holds:
//   - state encoding localparams: IDLE = 2'b00, ACCESS = 2'b01, CAPTURE = 2'b10
//   - requester ID constants: REQ_A = 1'b0, REQ_B = 1'b1
//  Sub-module rr_arbiter_2:
//   - inputs req[1:0], update strobe; output one-hot gnt
//   - owns last_gnt; combinational pick, registered pointer
//  FSM, cmd regs and read-return regs stay in the top module.
// TESTING
//  Bench instantiates regfile_access_arbiter together with a real Register_File (MEM_WIDTH = 16, MEM_DEPTH = 8).
//  1. Reset: RST = 1 for 2 cycles with Req_A = 1 -> all outputs 0; no Gnt until the first IDLE after RST falls.
//  2. A writes 16'hFF00 to address 0, then A reads address 0
//     -> Gnt_A at cycle 1; RdValid_A at cycle 3 of the read; RdData = 16'hFF00.
//  3. A and B both Req from reset:
//     - A = write 16'hFF0F to address 4; B = read address 4
//     - -> A granted first, then B; RdValid_B with RdData = 16'hFF0F.
//  4. Both Req held for 6 grants -> grant order A,B,A,B,A,B; RF_WrEn & RF_RdEn never both 1 (assertion).
//  5. Read of address 7 in flight, RST asserted in CAPTURE
//     -> no RdValid; RdData = 0; the next IDLE grants A.
//  6. No Req for 10 cycles after a read -> RdData holds its value; RF_WrEn = RF_RdEn = 0 throughout.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings for the register-file access arbiter: FSM states and requester IDs.
package regfile_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    CAPTURE = 2'b10
  } stateT;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bus of the register-file arbiter: two command ports and a shared read-return bus.
interface regfile_access_arbiter_if #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 8
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  logic                  Req_A;
  logic                  Req_B;
  logic                  Wr_A;
  logic                  Wr_B;
  logic [ADDR_WIDTH-1:0] Addr_A;
  logic [ADDR_WIDTH-1:0] Addr_B;
  logic [MEM_WIDTH-1:0]  WrData_A;
  logic [MEM_WIDTH-1:0]  WrData_B;
  logic                  Gnt_A;
  logic                  Gnt_B;
  logic                  RdValid_A;
  logic                  RdValid_B;
  logic [MEM_WIDTH-1:0]  RdData;

  modport master (
    output Req_A, Req_B, Wr_A, Wr_B, Addr_A, Addr_B, WrData_A, WrData_B,
    input  Gnt_A, Gnt_B, RdValid_A, RdValid_B, RdData
  );

  modport slave (
    input  Req_A, Req_B, Wr_A, Wr_B, Addr_A, Addr_B, WrData_A, WrData_B,
    output Gnt_A, Gnt_B, RdValid_A, RdValid_B, RdData
  );

endinterface

// File: rtl/register_file.sv
// Single-port register file: synchronous write, registered read one cycle after RdEn.
module Register_File #(
  parameter  int MEM_WIDTH  = 16,
  parameter  int MEM_DEPTH  = 8,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [MEM_WIDTH-1:0]  WrData,
  output logic [MEM_WIDTH-1:0]  RdData
);

  // NOTE: storage array has no reset; contents survive a controller reset and map to plain RAM.
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge CLK) begin
    if (WrEn) mem[Address] <= WrData;
    if (RdEn) RdData <= mem[Address];
  end

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: combinational one-hot grant, registered last-winner pointer.
module rr_arbiter_2
  import regfile_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic lastGnt;
  logic tiePick;

  // On a tie the requester that did not win last time goes first.
  assign tiePick = (lastGnt == REQ_B) ? REQ_A : REQ_B;

  always_comb begin
    // NOTE: gnt gets a default before any branch so no path leaves it unassigned (no latch).
    gnt = req;
    if (&req) begin
      gnt          = '0;
      gnt[tiePick] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lastGnt <= REQ_B;
    end else if (update) begin
      lastGnt <= gnt[REQ_B] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one single-port register file between requesters A and B: round-robin grant,
// one-cycle RF strobes from registered state, and a registered read-return bus.
module regfile_access_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter  int MEM_WIDTH  = 16,
  parameter  int MEM_DEPTH  = 8,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  regfile_access_arbiter_if.slave bus,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic [MEM_WIDTH-1:0]    RF_WrData,
  input  logic [MEM_WIDTH-1:0]    RF_RdData
);

  stateT                 state;
  logic                  cmdWr;
  logic                  cmdOwner;
  logic [ADDR_WIDTH-1:0] cmdAddr;
  logic [MEM_WIDTH-1:0]  cmdWrData;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       winB;
  logic       arbUpdate;

  assign req       = {bus.Req_B, bus.Req_A};
  assign winB      = gnt[REQ_B];
  assign arbUpdate = (state == IDLE) && (|req);

  rr_arbiter_2 uArb (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req),
    .update (arbUpdate),
    .gnt    (gnt)
  );

  // RF side decodes only from state and command registers, so both strobes can never coexist.
  assign RF_WrEn    = (state == ACCESS) && cmdWr;
  assign RF_RdEn    = (state == ACCESS) && !cmdWr;
  assign RF_Address = cmdAddr;
  assign RF_WrData  = cmdWrData;

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: non-blocking assignments so every register updates from its pre-edge value.
      state         <= IDLE;
      cmdWr         <= 1'b0;
      cmdOwner      <= REQ_A;
      cmdAddr       <= '0;
      cmdWrData     <= '0;
      bus.Gnt_A     <= 1'b0;
      bus.Gnt_B     <= 1'b0;
      bus.RdValid_A <= 1'b0;
      bus.RdValid_B <= 1'b0;
      bus.RdData    <= '0;
    end else begin
      bus.Gnt_A     <= 1'b0;
      bus.Gnt_B     <= 1'b0;
      bus.RdValid_A <= 1'b0;
      bus.RdValid_B <= 1'b0;

      case (state)
        IDLE: begin
          if (|req) begin
            cmdOwner  <= winB ? REQ_B : REQ_A;
            cmdWr     <= winB ? bus.Wr_B : bus.Wr_A;
            cmdAddr   <= winB ? bus.Addr_B : bus.Addr_A;
            cmdWrData <= winB ? bus.WrData_B : bus.WrData_A;
            bus.Gnt_A <= gnt[REQ_A];
            bus.Gnt_B <= gnt[REQ_B];
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          state <= cmdWr ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          bus.RdData    <= RF_RdData;
          bus.RdValid_A <= (cmdOwner == REQ_A);
          bus.RdValid_B <= (cmdOwner == REQ_B);
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
